// File: rtl/load_store_unit.sv
// Load/store unit: one CPU access at a time against a word-wide data memory.
// Define LSU_BYTE_ACCESS_EN to enable byte loads and read-modify-write byte stores.
module load_store_unit #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        req,
    input  logic        we,
    input  logic        byte_en,
    input  logic [10:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic [9:0]  Address,
    output logic [15:0] Write_Data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [15:0] Read_Data
);

    localparam int EffWait = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CntW    = (EffWait > 1) ? $clog2(EffWait) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(EffWait - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CntW-1:0] r_count;
    logic [9:0]      r_wordAddr;
    logic            r_we;
    logic [15:0]     r_wdata;
    logic            w_lastRead;
    logic            w_needsRead;
    logic [15:0]     w_loadValue;

    assign w_lastRead = (r_state == READ) && (r_count == LastCnt);

`ifdef LSU_BYTE_ACCESS_EN
    logic        r_byte;
    logic        r_lane;
    logic [15:0] r_sample;
    logic [7:0]  w_loadByte;
    logic [15:0] w_merged;

    // Byte stores must fetch the old word first, so they also start with a read
    assign w_needsRead = !we || byte_en;
    assign w_loadByte  = r_lane ? Read_Data[15:8] : Read_Data[7:0];
    assign w_loadValue = r_byte ? {{8{w_loadByte[7]}}, w_loadByte} : Read_Data;
    assign w_merged    = r_lane ? {r_wdata[7:0], r_sample[7:0]}
                                : {r_sample[15:8], r_wdata[7:0]};
`else
    logic w_unusedInputs;

    assign w_needsRead    = !we;
    assign w_loadValue    = Read_Data;
    assign w_unusedInputs = ^{byte_en, addr[0]};
`endif

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        busy       = 1'b1;
        done       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = r_wordAddr;
        Write_Data = 16'h0000;
        case (r_state)
            IDLE: begin
                busy    = 1'b0;
                Address = 10'h000;
                if (req) begin
                    w_next = w_needsRead ? READ : WRITE;
                end
            end
            READ: begin
                MemRead = 1'b1;
                if (w_lastRead) begin
                    w_next = r_we ? MERGE : DONE;
                end
            end
            MERGE: begin
                w_next = WRITE;
            end
            WRITE: begin
                MemWrite   = 1'b1;
                Write_Data = r_wdata;
                w_next     = DONE;
            end
            DONE: begin
                done    = 1'b1;
                Address = 10'h000;
                w_next  = IDLE;
            end
            default: begin
                busy    = 1'b0;
                Address = 10'h000;
                w_next  = IDLE;
            end
        endcase
    end

    // Request latch, read-wait counter and the load result register
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_count    <= '0;
            r_wordAddr <= 10'h000;
            r_we       <= 1'b0;
            r_wdata    <= 16'h0000;
            rdata      <= 16'h0000;
`ifdef LSU_BYTE_ACCESS_EN
            r_byte     <= 1'b0;
            r_lane     <= 1'b0;
            r_sample   <= 16'h0000;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_count    <= '0;
                        r_wordAddr <= addr[10:1];
                        r_we       <= we;
                        r_wdata    <= wdata;
`ifdef LSU_BYTE_ACCESS_EN
                        r_byte     <= byte_en;
                        r_lane     <= addr[0];
`endif
                    end
                end
                READ: begin
                    if (w_lastRead) begin
                        r_count <= '0;
                        if (!r_we) begin
                            rdata <= w_loadValue;
                        end
`ifdef LSU_BYTE_ACCESS_EN
                        r_sample <= Read_Data;
`endif
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
`ifdef LSU_BYTE_ACCESS_EN
                MERGE: begin
                    r_wdata <= w_merged;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, multi-cycle
// corner sequences, and random accesses against a memory-array reference model.
module tb_load_store_unit;

    localparam int WC = 3;
`ifdef LSU_BYTE_ACCESS_EN
    localparam bit ByteEn = 1'b1;
`else
    localparam bit ByteEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        Rst;
    logic        req;
    logic        we;
    logic        byte_en;
    logic [10:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic [15:0] rdata;
    logic [9:0]  Address;
    logic [15:0] Write_Data;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] Read_Data;

    logic [15:0] mem [0:1023];
    logic        memClear;
    logic [15:0] refMem [0:1023];
    logic [15:0] modelRd;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic        we;
        logic        be;
        logic [10:0] addr;
        logic [15:0] wdata;
        logic [15:0] expWd;
        logic [15:0] expRd;
    } vec_t;

    vec_t vecs [14];

    load_store_unit #(.WAIT_CYCLES(WC)) dut (
        .clk(clk),
        .Rst(Rst),
        .req(req),
        .we(we),
        .byte_en(byte_en),
        .addr(addr),
        .wdata(wdata),
        .busy(busy),
        .done(done),
        .rdata(rdata),
        .Address(Address),
        .Write_Data(Write_Data),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .Read_Data(Read_Data)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on the edge ending a MemWrite cycle
    assign Read_Data = mem[Address];

    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
        end else if (MemWrite) begin
            mem[Address] <= Write_Data;
        end
    end

    always @(negedge clk) begin
        testsRun++;
        if (MemRead && MemWrite) begin
            testsFailed++;
            $display("[TB] FAIL strobe exclusivity: got MemRead=1 MemWrite=1, expected at most one");
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic b, input logic [10:0] a,
                                input logic [15:0] d, input logic [15:0] ewd, input logic [15:0] erd);
        vec_t v;
        v.we = w; v.be = b; v.addr = a; v.wdata = d; v.expWd = ewd; v.expRd = erd;
        return v;
    endfunction

    // One access from accept through the first IDLE cycle, checked every cycle
    task automatic applyStimulus(input logic iWe, input logic iBe, input logic [10:0] iAddr,
                                 input logic [15:0] iWdata, input logic [15:0] expWd,
                                 input logic [15:0] expRd, input string name);
        logic        isByte;
        int          d;
        logic [9:0]  wa;
        logic [29:0] e;
        isByte = iBe && ByteEn;
        wa = iAddr[10:1];
        d = !iWe ? WC + 1 : (isByte ? WC + 3 : 2);
        @(negedge clk);
        req = 1'b1; we = iWe; byte_en = iBe; addr = iAddr; wdata = iWdata;
        @(posedge clk);
        for (int c = 1; c <= d + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req = 1'b0;
                we = 1'($urandom_range(0, 1));
                byte_en = 1'($urandom_range(0, 1));
                addr = 11'($urandom);
                wdata = 16'($urandom);
            end
            e = '0;
            if (c <= d) e[29] = 1'b1;
            if (c == d) begin
                e[28] = 1'b1;
            end else if (c < d) begin
                e[25:16] = wa;
                if (!iWe) begin
                    e[27] = 1'b1;
                end else if (!isByte) begin
                    e[26] = 1'b1;
                    e[15:0] = expWd;
                end else if (c <= WC) begin
                    e[27] = 1'b1;
                end else if (c == WC + 2) begin
                    e[26] = 1'b1;
                    e[15:0] = expWd;
                end
            end
            checkOutput($sformatf("%s c%0d outputs", name, c),
                        {2'b00, busy, done, MemRead, MemWrite, Address, Write_Data}, {2'b00, e});
            if (c == d) checkOutput($sformatf("%s rdata", name), {16'h0, rdata}, {16'h0, expRd});
        end
        if (iWe) refMem[wa] = expWd;
        modelRd = expRd;
    endtask

    initial begin
        logic [15:0] busyPat;
        logic [15:0] expPat;
        int          reads;
        int          dones;
        int          busySum;

        for (int i = 0; i < 1024; i++) refMem[i] = 16'h0000;
        modelRd = 16'h0000;
        req = 1'b0; we = 1'b0; byte_en = 1'b0; addr = '0; wdata = '0;
        Rst = 1'b1; memClear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        Rst = 1'b0; memClear = 1'b0;
        @(negedge clk);
        checkOutput("reset outputs", {2'b00, busy, done, MemRead, MemWrite, Address, Write_Data}, 32'h0);
        checkOutput("reset rdata", {16'h0, rdata}, 32'h0);

        vecs[0]  = mk(1'b1, 1'b0, 11'h010, 16'hBEEF, 16'hBEEF, 16'h0000);
        vecs[1]  = mk(1'b0, 1'b0, 11'h010, 16'h0000, 16'h0000, 16'hBEEF);
        vecs[2]  = mk(1'b1, 1'b0, 11'h7FE, 16'h1234, 16'h1234, 16'hBEEF);
        vecs[3]  = mk(1'b0, 1'b0, 11'h7FE, 16'h0000, 16'h0000, 16'h1234);
        vecs[4]  = mk(1'b0, 1'b0, 11'h000, 16'h0000, 16'h0000, 16'h0000);
        vecs[5]  = mk(1'b1, 1'b0, 11'h011, 16'h4321, 16'h4321, 16'h0000);
        vecs[6]  = mk(1'b0, 1'b0, 11'h010, 16'h0000, 16'h0000, 16'h4321);
        vecs[7]  = mk(1'b1, 1'b0, 11'h010, 16'h12F4, 16'h12F4, 16'h4321);
`ifdef LSU_BYTE_ACCESS_EN
        vecs[8]  = mk(1'b1, 1'b1, 11'h011, 16'h0056, 16'h56F4, 16'h4321);
        vecs[9]  = mk(1'b0, 1'b1, 11'h010, 16'h0000, 16'h0000, 16'hFFF4);
        vecs[10] = mk(1'b0, 1'b1, 11'h011, 16'h0000, 16'h0000, 16'h0056);
        vecs[11] = mk(1'b1, 1'b1, 11'h010, 16'hAA80, 16'h5680, 16'h0056);
        vecs[12] = mk(1'b0, 1'b1, 11'h010, 16'h0000, 16'h0000, 16'hFF80);
        vecs[13] = mk(1'b0, 1'b0, 11'h011, 16'h0000, 16'h0000, 16'h5680);
`else
        vecs[8]  = mk(1'b1, 1'b1, 11'h011, 16'h0056, 16'h0056, 16'h4321);
        vecs[9]  = mk(1'b0, 1'b1, 11'h010, 16'h0000, 16'h0000, 16'h0056);
        vecs[10] = mk(1'b0, 1'b1, 11'h011, 16'h0000, 16'h0000, 16'h0056);
        vecs[11] = mk(1'b1, 1'b1, 11'h010, 16'hAA80, 16'hAA80, 16'h0056);
        vecs[12] = mk(1'b0, 1'b1, 11'h010, 16'h0000, 16'h0000, 16'hAA80);
        vecs[13] = mk(1'b0, 1'b0, 11'h011, 16'h0000, 16'h0000, 16'hAA80);
`endif
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
                          vecs[i].expWd, vecs[i].expRd, $sformatf("vec%0d", i));
        end

        // Reset during the first READ cycle aborts the load and clears rdata
        @(negedge clk);
        req = 1'b1; we = 1'b0; byte_en = 1'b0; addr = 11'h010;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        checkOutput("abort in READ", {31'h0, MemRead}, 32'h1);
        Rst = 1'b1;
        @(negedge clk);
        Rst = 1'b0;
        checkOutput("abort outputs", {2'b00, busy, done, MemRead, MemWrite, Address, Write_Data}, 32'h0);
        checkOutput("abort rdata", {16'h0, rdata}, 32'h0);
        dones = 0; busySum = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            dones += int'(done);
            busySum += int'(busy);
        end
        checkOutput("abort no done", dones, 0);
        checkOutput("abort stays idle", busySum, 0);
        modelRd = 16'h0000;

        // req held high: ignored while busy, re-accepted in the IDLE cycle after DONE
        @(negedge clk);
        req = 1'b1; we = 1'b0; byte_en = 1'b0; addr = 11'h010;
        @(posedge clk);
        busyPat = '0; reads = 0; dones = 0;
        for (int c = 1; c <= 2 * WC + 4; c++) begin
            @(negedge clk);
            busyPat[c-1] = busy;
            reads += int'(MemRead);
            dones += int'(done);
            if (c == 2 * WC + 3) req = 1'b0;
        end
        expPat = '0;
        for (int c = 1; c <= 2 * WC + 4; c++) expPat[c-1] = (c != WC + 2) && (c != 2 * WC + 4);
        checkOutput("held req busy pattern", {16'h0, busyPat}, {16'h0, expPat});
        checkOutput("held req read cycles", reads, 2 * WC);
        checkOutput("held req done pulses", dones, 2);
        checkOutput("held req rdata", {16'h0, rdata}, {16'h0, refMem[8]});
        modelRd = refMem[8];

        for (int n = 0; n < 40; n++) begin
            logic        rWe;
            logic        rBe;
            logic        lane;
            logic        isB;
            logic [9:0]  wi;
            logic [15:0] wd;
            logic [15:0] old;
            logic [7:0]  bsel;
            logic [15:0] expWd;
            logic [15:0] expRd;
            rWe = 1'($urandom_range(0, 1));
            rBe = 1'($urandom_range(0, 1));
            lane = 1'($urandom_range(0, 1));
            wi = ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom_range(0, 7));
            wd = 16'($urandom);
            old = refMem[wi];
            bsel = lane ? old[15:8] : old[7:0];
            isB = rBe && ByteEn;
            if (rWe) begin
                expWd = isB ? (lane ? {wd[7:0], old[7:0]} : {old[15:8], wd[7:0]}) : wd;
                expRd = modelRd;
            end else begin
                expWd = 16'h0000;
                expRd = isB ? 16'($signed(bsel)) : old;
            end
            applyStimulus(rWe, rBe, {wi, lane}, wd, expWd, expRd, $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
